// File: rtl/simmem_delay_fifo.sv
// In-order delay FIFO: each entry carries its own release delay and may leave
// only once its counter reaches zero and every older entry has already left.
module simmem_delay_fifo #(
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned Capacity   = 16,
  parameter int unsigned DelayWidth = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [DataWidth-1:0]           data_i,
  input  logic [DelayWidth-1:0]          delay_i,
  input  logic                           data_in_valid_i,
  output logic                           data_in_ready_o,
  output logic [DataWidth-1:0]           data_o,
  output logic                           data_out_valid_o,
  input  logic                           data_out_ready_i,
  output logic [$clog2(Capacity+1)-1:0]  occupancy_o
);

  localparam int unsigned PtrWidth = $clog2(Capacity);
  localparam int unsigned OccWidth = $clog2(Capacity + 1);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Capacity - 1);

  logic [DataWidth-1:0]  storage_q [Capacity];
  logic [DelayWidth-1:0] cnt_q     [Capacity];
  logic [PtrWidth-1:0]   rd_ptr_q, wr_ptr_q;
  logic [OccWidth-1:0]   occ_q;
  logic                  push, pop;

  function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // Outputs depend on registered state only, so a full FIFO refuses a push
  // even while the head is being popped in the same cycle.
  assign data_in_ready_o  = (occ_q < OccWidth'(Capacity));
  assign data_out_valid_o = (occ_q != '0) && (cnt_q[rd_ptr_q] == '0);
  assign data_o           = storage_q[rd_ptr_q];
  assign occupancy_o      = occ_q;

  assign push = data_in_valid_i && data_in_ready_o;
  assign pop  = data_out_valid_o && data_out_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) storage_q[wr_ptr_q] <= data_i;
  end

  // Free slots always hold zero, so counting every slot down is harmless and
  // lets queued entries age while they wait behind the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Capacity); i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(Capacity); i++) begin
        if (push && (wr_ptr_q == PtrWidth'(i))) cnt_q[i] <= delay_i;
        else if (cnt_q[i] != '0)                cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_simmem_delay_fifo.sv
// Bench for simmem_delay_fifo: fixed vector table, hand sequences, and random
// traffic checked against a queue-based reference model.
module tb_simmem_delay_fifo;

  localparam int DW = 8;
  localparam int CAP = 4;
  localparam int LW = 8;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [DW-1:0] data_i;
  logic [LW-1:0] delay_i;
  logic          data_in_valid_i;
  logic          data_in_ready_o;
  logic [DW-1:0] data_o;
  logic          data_out_valid_o;
  logic          data_out_ready_i;
  logic [2:0]    occupancy_o;

  simmem_delay_fifo #(.DataWidth(DW), .Capacity(CAP), .DelayWidth(LW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .delay_i(delay_i),
    .data_in_valid_i(data_in_valid_i), .data_in_ready_o(data_in_ready_o),
    .data_o(data_o), .data_out_valid_o(data_out_valid_o),
    .data_out_ready_i(data_out_ready_i), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: ordered list of entries with cycles left before release.
  typedef struct { int d; int left; } ent_t;
  ent_t mq[$];

  function automatic bit m_valid();
    return (mq.size() != 0) && (mq[0].left == 0);
  endfunction

  function automatic bit m_ready();
    return mq.size() < CAP;
  endfunction

  function automatic void m_edge(input bit push, input int d, input int dl, input bit pop);
    foreach (mq[i]) if (mq[i].left > 0) mq[i].left--;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back('{d: d, left: dl});
  endfunction

  // One clock with model-derived expectations; returns whether a pop occurred.
  task automatic drive_cycle(input bit iv, input int d, input int dl, input bit ordy,
                             input string tag, output bit popped, output int pop_d);
    bit push, pop;
    data_in_valid_i  = iv;
    data_i           = DW'(d);
    delay_i          = LW'(dl);
    data_out_ready_i = ordy;
    @(negedge clk_i);
    chk({tag, "_ready"}, int'(data_in_ready_o), int'(m_ready()));
    chk({tag, "_valid"}, int'(data_out_valid_o), int'(m_valid()));
    chk({tag, "_occ"}, int'(occupancy_o), mq.size());
    if (m_valid()) chk({tag, "_data"}, int'(data_o), mq[0].d);
    push   = iv && m_ready();
    pop    = m_valid() && ordy;
    popped = pop;
    pop_d  = int'(data_o);
    @(posedge clk_i);
    m_edge(push, d, dl, pop);
    #1;
  endtask

  typedef struct {
    bit iv; int d; int dl; bit ordy;
    bit exp_rdy; bit exp_v; int exp_d; int exp_occ;
  } vec_t;
  vec_t vecs[$];

  function automatic void addv(input bit iv, input int d, input int dl, input bit ordy,
                               input bit er, input bit ev, input int ed, input int eo);
    vecs.push_back('{iv: iv, d: d, dl: dl, ordy: ordy,
                     exp_rdy: er, exp_v: ev, exp_d: ed, exp_occ: eo});
  endfunction

  task automatic run_row(input vec_t v, input int idx);
    bit push, pop;
    string tag;
    tag = $sformatf("vec%0d", idx);
    data_in_valid_i  = v.iv;
    data_i           = DW'(v.d);
    delay_i          = LW'(v.dl);
    data_out_ready_i = v.ordy;
    @(negedge clk_i);
    chk({tag, "_ready"}, int'(data_in_ready_o), int'(v.exp_rdy));
    chk({tag, "_valid"}, int'(data_out_valid_o), int'(v.exp_v));
    chk({tag, "_occ"}, int'(occupancy_o), v.exp_occ);
    if (v.exp_v) chk({tag, "_data"}, int'(data_o), v.exp_d);
    push = v.iv && m_ready();
    pop  = m_valid() && v.ordy;
    @(posedge clk_i);
    m_edge(push, v.d, v.dl, pop);
    #1;
  endtask

  initial begin
    bit popped;
    int pd, sent, got, budget;

    rst_ni = 1'b0;
    data_i = '0; delay_i = '0; data_in_valid_i = 1'b0; data_out_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, "idle", popped, pd);

    // Delay 0 single entry; delay ordering; full FIFO with simultaneous pop.
    addv(1, 'hA5, 0, 1,  1, 0, 0,     0);
    addv(0, 0,    0, 1,  1, 1, 'hA5,  1);
    addv(0, 0,    0, 1,  1, 0, 0,     0);
    addv(1, 'h11, 5, 1,  1, 0, 0,     0);
    addv(1, 'h22, 0, 1,  1, 0, 0,     1);
    for (int i = 0; i < 4; i++) addv(0, 0, 0, 1, 1, 0, 0, 2);
    addv(0, 0,    0, 1,  1, 1, 'h11,  2);
    addv(0, 0,    0, 1,  1, 1, 'h22,  1);
    addv(0, 0,    0, 1,  1, 0, 0,     0);
    addv(1, 'h31, 0, 0,  1, 0, 0,     0);
    addv(1, 'h32, 0, 0,  1, 1, 'h31,  1);
    addv(1, 'h33, 0, 0,  1, 1, 'h31,  2);
    addv(1, 'h34, 0, 0,  1, 1, 'h31,  3);
    addv(1, 'h35, 0, 1,  0, 1, 'h31,  4);
    addv(1, 'h35, 0, 0,  1, 1, 'h32,  3);
    addv(0, 0,    0, 0,  0, 1, 'h32,  4);
    addv(0, 0,    0, 1,  0, 1, 'h32,  4);
    addv(0, 0,    0, 1,  1, 1, 'h33,  3);
    addv(0, 0,    0, 1,  1, 1, 'h34,  2);
    addv(0, 0,    0, 1,  1, 1, 'h35,  1);
    addv(0, 0,    0, 1,  1, 0, 0,     0);
    foreach (vecs[i]) run_row(vecs[i], i);

    // Wrap: ten entries through the ring, random delays and back-pressure.
    sent = 0; got = 0; budget = 0;
    while (got < 10 && budget < 500) begin
      drive_cycle(sent < 10, sent, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                  "wrap", popped, pd);
      if (sent < 10 && mq.size() > 0 && mq[$].d == sent) sent++;
      if (popped) begin
        chk("wrap_order", pd, got);
        got++;
      end
      budget++;
    end
    if (budget >= 500) chk("wrap_timeout", got, 10);

    // Random traffic.
    for (int i = 0; i < 300; i++)
      drive_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                  $urandom_range(0, 6), 1'($urandom_range(0, 1)), "rand", popped, pd);

    budget = 0;
    while (mq.size() != 0 && budget < 100) begin
      drive_cycle(0, 0, 0, 1, "drain", popped, pd);
      budget++;
    end
    if (budget >= 100) chk("drain_timeout", mq.size(), 0);

    // Hold valid under back-pressure, then reset with entries stored.
    drive_cycle(1, 'h5A, 0, 0, "hold", popped, pd);
    drive_cycle(1, 'h6B, 2, 0, "hold", popped, pd);
    drive_cycle(1, 'h7C, 0, 0, "hold", popped, pd);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 0, "hold", popped, pd);
      chk("hold_data_const", int'(data_o), 'h5A);
      chk("hold_valid_const", int'(data_out_valid_o), 1);
    end
    chk("pre_rst_occ", int'(occupancy_o), 3);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", int'(data_out_valid_o), 0);
    chk("async_rst_ready", int'(data_in_ready_o), 1);
    chk("async_rst_occ", int'(occupancy_o), 0);
    mq.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    drive_cycle(0, 0, 0, 1, "post_rst", popped, pd);
    drive_cycle(1, 'h99, 1, 1, "post_rst", popped, pd);
    for (int i = 0; i < 4; i++) drive_cycle(0, 0, 0, 1, "post_rst", popped, pd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
